// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register-file slave.
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Word-slot index from a byte address; the low two bits select a byte
  // lane and are ignored, bits at and above addr_width are discarded.
  function automatic int unsigned addr_index(input logic [31:0] addr,
                                             input int unsigned addr_width);
    logic [31:0] word;
    logic [31:0] mask;
    word = addr >> 2;
    mask = (32'd1 << (addr_width - 2)) - 32'd1;
    return word & mask;
  endfunction

endpackage

// File: rtl/axil_slave_wr_ctrl.sv
// AXI4-Lite write-side control: independent AW/W capture, commit strobe
// and B channel. Presents the committed index and strobe-masked data.
module axil_slave_wr_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output axil_resp_t              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    commit,
  output logic                    commit_ok,
  output logic [ADDR_WIDTH-3:0]   commit_index,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH-1:0]   commit_mask
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  aw_held, w_held;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  axil_resp_t            b_resp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]     strb_q;

  logic                  aw_hs, w_hs;
  logic                  aw_held_n, w_held_n, b_valid_n;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [STRB_W-1:0]     strb_sel;
  int unsigned           idx;
  logic                  in_range;

  // Handshake detection, commit decision and next-state of the held flags.
  // A half that handshakes this cycle bypasses its holding register so the
  // commit can happen on the same edge as the last handshake.
  always_comb begin
    aw_hs     = aw_valid && aw_ready_q;
    w_hs      = w_valid && w_ready_q;
    commit    = (aw_held || aw_hs) && (w_held || w_hs);
    addr_sel  = aw_hs ? aw_addr : addr_q;
    data_sel  = w_hs ? w_data : data_q;
    strb_sel  = w_hs ? w_strb : strb_q;
    idx       = addr_index(32'(addr_sel), ADDR_WIDTH);
    in_range  = idx < NUM_REGS;
    aw_held_n = commit ? 1'b0 : (aw_held || aw_hs);
    w_held_n  = commit ? 1'b0 : (w_held || w_hs);
    b_valid_n = commit ? 1'b1 : (b_valid_q && !b_ready);
    commit_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      commit_mask[8*b +: 8] = {8{strb_sel[b]}};
    end
    commit_data  = data_sel & commit_mask;
    commit_ok    = in_range;
    commit_index = IDX_W'(idx);
  end

  // Holding registers, registered readies and B channel state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      aw_held    <= aw_held_n;
      w_held     <= w_held_n;
      b_valid_q  <= b_valid_n;
      aw_ready_q <= !aw_held_n && !b_valid_n;
      w_ready_q  <= !w_held_n && !b_valid_n;
      if (aw_hs) addr_q <= aw_addr;
      if (w_hs) begin
        data_q <= w_data;
        strb_q <= w_strb;
      end
      if (commit) b_resp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit registers with byte
// strobes, OKAY/SLVERR responses, flattened contents and write pulses.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  wr_commit, wr_ok;
  logic [ADDR_WIDTH-3:0] wr_index;
  logic [DATA_WIDTH-1:0] wr_data, wr_mask;
  axil_resp_t            b_resp;

  logic                  ar_ready_q, r_valid_q, r_valid_n, ar_hs;
  logic [DATA_WIDTH-1:0] r_data_q, rd_word;
  axil_resp_t            r_resp_q;
  int unsigned           rd_idx;
  logic                  rd_ok;

  // Protection attributes carry no meaning for this target.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  axil_slave_wr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .aw_addr      (S_AXI_AWADDR),
    .aw_valid     (S_AXI_AWVALID),
    .aw_ready     (S_AXI_AWREADY),
    .w_data       (S_AXI_WDATA),
    .w_strb       (S_AXI_WSTRB),
    .w_valid      (S_AXI_WVALID),
    .w_ready      (S_AXI_WREADY),
    .b_resp       (b_resp),
    .b_valid      (S_AXI_BVALID),
    .b_ready      (S_AXI_BREADY),
    .commit       (wr_commit),
    .commit_ok    (wr_ok),
    .commit_index (wr_index),
    .commit_data  (wr_data),
    .commit_mask  (wr_mask)
  );

  assign S_AXI_BRESP = b_resp;

  // Register array update and one-cycle write pulses on commit.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && wr_ok && (32'(wr_index) == i)) begin
          regs[i]   <= (regs[i] & ~wr_mask) | wr_data;
          reg_wr[i] <= 1'b1;
        end
      end
    end
  end

  // Read address decode and register select; the array is read before the
  // same edge's write lands, so a colliding read returns the old value.
  always_comb begin
    ar_hs     = S_AXI_ARVALID && ar_ready_q;
    rd_idx    = addr_index(32'(S_AXI_ARADDR), ADDR_WIDTH);
    rd_ok     = rd_idx < NUM_REGS;
    r_valid_n = ar_hs ? 1'b1 : (r_valid_q && !S_AXI_RREADY);
    rd_word   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == i) rd_word = regs[i];
    end
  end

  // R channel state and registered AR ready.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      r_valid_q  <= r_valid_n;
      ar_ready_q <= !r_valid_n;
      if (ar_hs) begin
        r_data_q <= rd_ok ? rd_word : '0;
        r_resp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Flattened view of the register array.
  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
    end
  end

  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = r_resp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed self-checking bench for axil_slave_regfile.
module tb_axil_slave_regfile;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  axil_slave_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (4)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_q         (reg_q),
    .reg_wr        (reg_wr)
  );

  // Single write; entered and left at a falling edge. Returns BRESP and
  // the reg_wr value seen in the BVALID cycle.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output logic [3:0] pulse);
    int unsigned n;
    logic aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    resp = bresp;
    pulse = reg_wr;
    checks++;
    if (!bvalid || awvalid || wvalid) begin
      errors++;
      $display("FAIL write_timeout addr=%h: bvalid=%b expected 1", a, bvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Single read; entered and left at a falling edge.
  task automatic do_read(input logic [4:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int unsigned n;
    logic ar_go;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      ar_go = arvalid && arready;
      @(negedge clk);
      if (ar_go) arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    d = rdata;
    resp = rresp;
    checks++;
    if (!rvalid || arvalid) begin
      errors++;
      $display("FAIL read_timeout addr=%h: rvalid=%b expected 1", a, rvalid);
      arvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b expected 0", awready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b expected 0", wready); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b expected 0", arready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b expected 0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", rvalid); end
    checks++; if (reg_q !== 128'h0) begin errors++; $display("FAIL rst_reg_q: got %h expected 0", reg_q); end
    checks++; if (reg_wr !== 4'h0) begin errors++; $display("FAIL rst_reg_wr: got %b expected 0", reg_wr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    aresetn = 1'b1;
    @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL rst_release_readies: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic_rw();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    logic [3:0] exp_pulse;
    for (int i = 0; i < 4; i++) begin
      do_write(5'(4 * i), 32'(i + 1), 4'hF, resp, pulse);
      exp_pulse = 4'b0001 << i;
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp[%0d]: got %b expected 00", i, resp); end
      checks++; if (pulse !== exp_pulse) begin errors++; $display("FAIL basic_reg_wr[%0d]: got %b expected %b", i, pulse, exp_pulse); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), d, resp);
      checks++; if (d !== 32'(i + 1)) begin errors++; $display("FAIL basic_rdata[%0d]: got %h expected %h", i, d, 32'(i + 1)); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_rresp[%0d]: got %b expected 00", i, resp); end
    end
    checks++; if (reg_q !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL basic_reg_q: got %h expected 00000004000000030000000200000001", reg_q); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    do_write(5'h00, 32'hAABBCCDD, 4'hF, resp, pulse);
    do_write(5'h00, 32'h11223344, 4'h5, resp, pulse);
    checks++; if (pulse !== 4'b0001) begin errors++; $display("FAIL strobe_reg_wr: got %b expected 0001", pulse); end
    do_read(5'h00, d, resp);
    checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_rdata: got %h expected aa22cc44", d); end
  endtask

  task automatic test_w_before_aw();
    int unsigned pulses;
    pulses = 0;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready: got %b expected 1", wready); end
    wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_early_bvalid[%0d]: got %b expected 0", i, bvalid); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_held[%0d]: got %b expected 0", i, wready); end
      if (reg_wr !== 4'h0) pulses++;
      if (i == 2) begin
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL wfirst_awready: got %b expected 1", awready); end
        awaddr = 5'h00; awvalid = 1'b1;
      end
      @(negedge clk);
    end
    awvalid = 1'b0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL wfirst_bvalid: got %b expected 1", bvalid); end
    checks++; if (reg_wr !== 4'b0001) begin errors++; $display("FAIL wfirst_reg_wr: got %b expected 0001", reg_wr); end
    for (int i = 0; i < 4; i++) begin
      if (reg_wr !== 4'h0) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wfirst_pulse_count: got %0d expected 1", pulses); end
    checks++; if (reg_q[31:0] !== 32'h00000055) begin errors++; $display("FAIL wfirst_reg0: got %h expected 00000055", reg_q[31:0]); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    do_write(5'h10, 32'hFFFFFFFF, 4'hF, resp, pulse);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL slverr_bresp: got %b expected 10", resp); end
    checks++; if (pulse !== 4'h0) begin errors++; $display("FAIL slverr_reg_wr: got %b expected 0000", pulse); end
    do_read(5'h10, d, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL slverr_rresp: got %b expected 10", resp); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL slverr_rdata: got %h expected 0", d); end
    checks++; if (reg_q !== 128'h00000004_00000003_00000002_00000055) begin errors++; $display("FAIL slverr_reg_q: got %h expected 00000004000000030000000200000055", reg_q); end
  endtask

  task automatic test_backpressure();
    bready = 1'b0;
    awaddr = 5'h04; wdata = 32'hCAFE0004; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awaddr = 5'h08; wdata = 32'h00000077; wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bp_bvalid[%0d]: got %b expected 1", i, bvalid); end
      checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL bp_bresp[%0d]: got %b expected 00", i, bresp); end
      checks++; if ({awready, wready} !== 2'b00) begin errors++; $display("FAIL bp_readies[%0d]: got %b expected 00", i, {awready, wready}); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_bvalid_drop: got %b expected 0", bvalid); end
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL bp_readies_back: got %b expected 11", {awready, wready}); end
    checks++; if (reg_q[95:64] !== 32'h00000003) begin errors++; $display("FAIL bp_second_early: got %h expected 00000003", reg_q[95:64]); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bp_second_bvalid: got %b expected 1", bvalid); end
    checks++; if (reg_q[95:32] !== 64'h00000077_CAFE0004) begin errors++; $display("FAIL bp_regs: got %h expected 00000077cafe0004", reg_q[95:32]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h0000DEAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL mid_valids_up: got %b expected 11", {bvalid, rvalid}); end
    checks++; if (rdata !== 32'h00000055) begin errors++; $display("FAIL mid_rdata: got %h expected 00000055", rdata); end
    aresetn = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL mid_valids_cleared: got %b expected 00", {bvalid, rvalid}); end
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL mid_readies_cleared: got %b expected 000", {awready, wready, arready}); end
    checks++; if (reg_q !== 128'h0) begin errors++; $display("FAIL mid_reg_q: got %h expected 0", reg_q); end
    aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL mid_readies_back: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    do_write(5'h04, 32'h12345678, 4'hF, resp, pulse);
    awaddr = 5'h04; wdata = 32'h00000009; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL b2b_valids: got %b expected 11", {bvalid, rvalid}); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_prewrite_rdata: got %h expected 12345678", rdata); end
    checks++; if (reg_q[63:32] !== 32'h00000009) begin errors++; $display("FAIL b2b_reg1: got %h expected 00000009", reg_q[63:32]); end
    @(negedge clk);
    checks++; if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL b2b_readies: got %b expected 11", {awready, arready}); end
    do_read(5'h04, d, resp);
    checks++; if (d !== 32'h00000009) begin errors++; $display("FAIL b2b_rdata: got %h expected 00000009", d); end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_rw();
    test_strobe();
    test_w_before_aw();
    test_slverr();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave_regfile.md
# axil_slave_regfile

AXI4-Lite slave register file implementing the S00_AXI target inside the IP wrapper: the responder that answers the master VIP's single-beat writes and reads. It holds NUM_REGS 32-bit software-visible registers, applies byte strobes, returns OKAY/SLVERR responses, and exports register contents and per-register write pulses to wrapper logic.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 5, byte-address width; decodes 2^(ADDR_WIDTH-2) word slots.
- NUM_REGS, 4, implemented registers at word slots 0..NUM_REGS-1; must be ≤ 2^(ADDR_WIDTH-2).

- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset; synchronous, active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  AW handshake.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4  byte enables; S_AXI_WVALID in 1 / S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1 / S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID out 1 / S_AXI_RREADY in 1.
- reg_q  out  NUM_REGS*32  flattened register contents, reg i at [32i+31:32i].
- reg_wr  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written.

## Operation
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. index < NUM_REGS → OKAY (2'b00); otherwise SLVERR (2'b10), no register change, read data 0.
- Write path: AW and W are accepted independently, in either order or the same cycle. Each is captured into a holding register (aw_held, w_held). AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
- Commit occurs in the cycle where both are present (held or handshaking now). On that edge:
  - bytes with WSTRB=1 are written;
  - both held flags clear;
  - BVALID rises with BRESP;
  - reg_wr[index] pulses if in range.
- BVALID stays high with stable BRESP until BREADY. Both write readies are low while BVALID is high.
- Read path: ARREADY = !RVALID. On the AR handshake edge, RDATA/RRESP are latched and RVALID rises. They are held stable until RREADY, then RVALID falls and ARREADY returns the next cycle.
- Read and write paths are independent and may be active in the same cycle. A read handshake on the same edge as a commit to the same register returns the pre-write value.
- WSTRB = 0 with an in-range address: OKAY, no data change, reg_wr still pulses.

## Timing
- Reset (ARESETN=0 at an edge) sets:
  - all registers, held flags, BVALID, RVALID, BRESP, RRESP, RDATA, reg_wr to 0;
  - AWREADY, WREADY, ARREADY to 0.
- Readies are registered; they go high on the first edge with ARESETN=1.
- Reset asserted mid-transaction drops any pending AW/W/B/R with no response. Registers return to 0.
- Write latency: last of AW/W handshakes at edge N → register updated and BVALID=1 after edge N. With BREADY held high, BVALID is 1 for one cycle. The next AW/W can be accepted in the cycle after BVALID falls; peak throughput is one write per 2 cycles.
- Read latency: AR handshake at edge N → RVALID=1 after edge N. Peak throughput is one read per 2 cycles.
- All outputs come from flops; no combinational path from any VALID/READY input to any output.

## Structure
- Package axil_pkg holds shared definitions:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - typedef axil_resp_t (logic [1:0]);
  - function addr_index() shared by both paths.
- Sub-module axil_slave_wr_ctrl holds the AW/W holding registers, commit strobe and B channel. Its outputs are commit, index and strobe-masked data. The top level holds the register array and read path.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C (WSTRB=0xF), then read the same addresses → RDATA 0x1..0x4, all RRESP=OKAY; reg_q = 0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x00 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5 → read 0x00 returns 0xAA22CC44.
- Present WVALID 3 cycles before AWVALID → no BVALID until the AW handshake; BVALID one cycle after it; reg_wr[0] pulses once.
- Write and read 0x10 (slot 4, unimplemented) → BRESP=SLVERR, RRESP=SLVERR, RDATA=0; reg_q unchanged.
- Hold BREADY=0 for 5 cycles after a write → BVALID and BRESP stable, AWREADY=WREADY=0 throughout; a second write is accepted only after the B handshake.
- Assert ARESETN=0 while BVALID=1 and RVALID=1 → next cycle all valids, readies and registers are 0; readies return one cycle after release.
